// File: rtl/nibble_add_pkg.sv
// Shared types and helpers for the nibble-serial adder sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package nibble_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int NIBBLE_W = 4;

   // Number of nibble steps needed to cover an operand of the given width.
   function automatic int nibbles_of(input int width);
      return width / NIBBLE_W;
   endfunction

endpackage

// File: rtl/four_bit_adder.sv
// Combinational 4-bit ripple adder slice with carry in/out.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs.
module four_bit_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   // Widen to 5 bits so the carry out falls out of the addition directly.
   assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add (optional subtract via SUBTRACT_EN) using one 4-bit slice, LSB nibble first.
// Latency: WIDTH/4 cycles from accept edge to out_valid.
// Backpressure: in_ready only in IDLE; DONE holds all outputs frozen until out_ready.
import nibble_add_pkg::*;

module nibble_serial_add_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
`ifdef SUBTRACT_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             busy
);

   localparam int NIBBLES = nibbles_of(WIDTH);
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int OFF_W   = IDX_W + 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   // Reject widths that do not split into whole nibbles.
   generate
      if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
         $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q, cout_d;

   logic [OFF_W-1:0]    bit_off;
   logic [NIBBLE_W-1:0] slice_a;
   logic [NIBBLE_W-1:0] slice_b;
   logic [NIBBLE_W-1:0] slice_sum;
   logic                slice_cout;

   // Bit offset of the nibble currently being processed (idx * 4).
   assign bit_off = {idx_q, 2'b00};
   assign slice_a = a_q[bit_off +: NIBBLE_W];
   assign slice_b = b_q[bit_off +: NIBBLE_W];

   four_bit_adder u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // Next-state logic: accept operands, step one nibble per RUN cycle, hold in DONE.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      cout_d   = cout_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d = op_a;
`ifdef SUBTRACT_EN
               // Subtract as a + ~b + 1; cin is irrelevant in that mode.
               if (sub) begin
                  b_d     = ~op_b;
                  carry_d = 1'b1;
               end else begin
                  b_d     = op_b;
                  carry_d = cin;
               end
`else
               b_d     = op_b;
               carry_d = cin;
`endif
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            result_d[bit_off +: NIBBLE_W] = slice_sum;
            carry_d = slice_cout;
            if (idx_q == LAST_IDX) begin
               cout_d  = slice_cout;
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything so an aborted op leaves no trace.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         cout_q   <= cout_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign result    = result_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomized self-checking bench for nibble_serial_add_ctrl (WIDTH=16), with optional SUBTRACT_EN cases.
// Latency: checks out_valid exactly 4 cycles after each accept.
// Backpressure: holds out_ready low in DONE and pulses in_valid while busy.
module tb_nibble_serial_add_ctrl;

   localparam int W   = 16;
   localparam int NIB = W / 4;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic          cin;
`ifdef SUBTRACT_EN
   logic          sub;
`endif
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic          cout;
   logic          busy;

   int n_cmp = 0;
   int n_bad = 0;

   nibble_serial_add_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .cin       (cin),
`ifdef SUBTRACT_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: the full-width arithmetic result {carry, sum}.
   function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c, input logic s);
      logic [W-1:0] nb;
      nb = ~b;
      if (s) return (W+1)'(a) + (W+1)'(nb) + (W+1)'(1);
      else   return (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
   endfunction

   // Behavioural model: an op is "active" from accept until released; result appears NIB edges later.
   logic          m_active = 1'b0;
   int            m_age    = 0;
   logic [W-1:0]  m_res    = '0;
   logic          m_cout   = 1'b0;
   logic [W:0]    m_pend   = '0;

   always @(posedge clk) begin
      logic s_eff;
`ifdef SUBTRACT_EN
      s_eff = sub;
`else
      s_eff = 1'b0;
`endif
      if (rst) begin
         m_active = 1'b0;
         m_age    = 0;
         m_res    = '0;
         m_cout   = 1'b0;
      end else if (!m_active) begin
         if (in_valid) begin
            m_active = 1'b1;
            m_age    = 0;
            m_pend   = ref_sum(op_a, op_b, cin, s_eff);
         end
      end else if (m_age < NIB) begin
         m_age = m_age + 1;
         if (m_age == NIB) begin
            m_res  = m_pend[W-1:0];
            m_cout = m_pend[W];
         end
      end else if (out_ready) begin
         m_active = 1'b0;
      end
   end

   // Compare on the falling edge, away from state updates.
   always @(negedge clk) begin
      if (rst) begin
         check("rst_in_ready", 32'(in_ready), 32'd1);
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_result", 32'(result), 32'd0);
         check("rst_cout", 32'(cout), 32'd0);
      end else begin
         check("in_ready", 32'(in_ready), 32'(!m_active));
         check("busy", 32'(busy), 32'(m_active));
         check("out_valid", 32'(out_valid), 32'(m_active && m_age == NIB));
         if (!(m_active && m_age < NIB)) begin
            check("result", 32'(result), 32'(m_res));
            check("cout", 32'(cout), 32'(m_cout));
         end
      end
   end

   task automatic drive_garbage();
      op_a = W'($urandom);
      op_b = W'($urandom);
      cin  = 1'($urandom);
`ifdef SUBTRACT_EN
      sub  = 1'($urandom);
`endif
   endtask

   // Issue one operation and see it through; optionally pin literal expectations.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s, input int hold, input bit lit,
                        input logic [W-1:0] exp_r, input logic exp_c, input string name);
      int n;
      int lat;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check({name, "_ready_before_issue"}, 32'(in_ready), 32'd1);
      op_a = a;
      op_b = b;
      cin  = c;
`ifdef SUBTRACT_EN
      sub  = s;
`else
      if (s) $display("note: subtract request ignored in add-only build");
`endif
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      drive_garbage();
      lat = 0;
      while (!out_valid && lat < 50) begin
         in_valid = ($urandom_range(0, 3) == 0);
         drive_garbage();
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      check({name, "_out_valid_reached"}, 32'(out_valid), 32'd1);
      if (lit) begin
         check({name, "_latency"}, 32'(lat), 32'(NIB));
         check({name, "_result"}, 32'(result), 32'(exp_r));
         check({name, "_cout"}, 32'(cout), 32'(exp_c));
         check({name, "_model_result"}, 32'(m_res), 32'(exp_r));
         check({name, "_model_cout"}, 32'(m_cout), 32'(exp_c));
      end
      repeat (hold) begin
         in_valid = 1'($urandom);
         drive_garbage();
         @(posedge clk); #1;
      end
      if (lit && hold > 0) begin
         check({name, "_held_result"}, 32'(result), 32'(exp_r));
         check({name, "_held_in_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op_a      = '0;
      op_b      = '0;
      cin       = 1'b0;
`ifdef SUBTRACT_EN
      sub       = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      do_op(16'h0000, 16'h0000, 1'b0, 1'b0, 0, 1, 16'h0000, 1'b0, "zero");
      do_op(16'h5A5A, 16'hA5A5, 1'b0, 1'b0, 1, 1, 16'hFFFF, 1'b0, "alt_c0");
      do_op(16'h5A5A, 16'hA5A5, 1'b1, 1'b0, 0, 1, 16'h0000, 1'b1, "alt_c1");
      do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 5, 1, 16'hFFFF, 1'b1, "ones_hold");

      // Abort during the second RUN cycle.
      while (!in_ready) begin @(posedge clk); #1; end
      op_a = 16'hFFFF; op_b = 16'hFFFF; cin = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      check("abort_result", 32'(result), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1, 16'h0002, 1'b0, "after_abort");

`ifdef SUBTRACT_EN
      do_op(16'h1234, 16'h0235, 1'b0, 1'b1, 0, 1, 16'h0FFF, 1'b1, "sub_noborrow");
      do_op(16'h0001, 16'h0002, 1'b1, 1'b1, 0, 1, 16'hFFFF, 1'b0, "sub_borrow");
      do_op(16'h0001, 16'h0002, 1'b0, 1'b0, 0, 1, 16'h0003, 1'b0, "sub0_add");
`endif

      for (int i = 0; i < 30; i++) begin
         logic s_r;
`ifdef SUBTRACT_EN
         s_r = 1'($urandom);
`else
         s_r = 1'b0;
`endif
         do_op(W'($urandom), W'($urandom), 1'($urandom), s_r,
               $urandom_range(0, 3), 0, '0, 1'b0, "rand");
      end

      repeat (3) begin @(posedge clk); #1; end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/nibble_serial_add_ctrl.md
# nibble_serial_add_ctrl

Sequencer that performs WIDTH-bit additions by time-multiplexing a single `four_bit_adder` slice, one nibble per clock, LSB nibble first. It sits between an operand producer and a result consumer with valid/ready handshakes on both sides. It trades latency for area when wide adds are infrequent.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥4, otherwise elaboration error.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set offered.
- in_ready  output  1  block accepts operands; high only in IDLE.
- op_a  input  WIDTH  addend A.
- op_b  input  WIDTH  addend B.
- cin  input  1  carry-in to nibble 0.
- out_valid  output  1  result/cout valid; high only in DONE.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  registered sum.
- cout  output  1  registered carry out of the top nibble.
- busy  output  1  high in RUN or DONE.

## Operation
- NIBBLES = WIDTH/4; nibble counter `idx` is $clog2(NIBBLES) bits wide, minimum 1.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch op_a, op_b; seed carry register with cin; clear idx; go to RUN. result and cout keep their previous values until overwritten.
- RUN: the adder slice sees a_reg[4*idx+:4], b_reg[4*idx+:4] and the carry register. At each edge, write the slice sum into result[4*idx+:4], load the carry register with the slice cout, and increment idx.
  - When idx==NIBBLES-1, load cout from the slice cout and go to DONE.
- DONE: out_valid=1; result and cout are stable. On out_ready, go to IDLE.
- Inputs other than rst, in_valid and out_ready are ignored outside the accept edge.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the true bit WIDTH of a+b+cin.
- Reset (asserted at any time, including mid-RUN) forces:
  - state IDLE, idx 0, carry register 0, result 0, cout 0, out_valid 0;
  - in_ready 1, busy 0.
  - An aborted operation produces no output.

## Timing
- Accept edge E0. RUN occupies cycles E0..E0+NIBBLES-1.
- out_valid rises after edge E0+NIBBLES. Latency is NIBBLES cycles; WIDTH=16 gives 4, WIDTH=4 gives 1.
- in_ready is combinational from state. It is not asserted in the DONE cycle in which out_ready is seen.
- Minimum issue period is NIBBLES+2 cycles: one IDLE cycle, NIBBLES RUN cycles, one DONE cycle.
- Backpressure: DONE holds indefinitely with all outputs frozen.

## Configuration
- SUBTRACT_EN defined:
  - Adds port `sub  input  1`, sampled at the accept edge.
  - With sub=1: b_reg is loaded with ~op_b, the carry register is seeded with 1, and cin is ignored. result = op_a−op_b mod 2^WIDTH; cout=1 means no borrow.
  - With sub=0: behaviour is identical to the add-only build.
- SUBTRACT_EN undefined: no `sub` port; add only.

## Structure
- Package `nibble_add_pkg`:
  - state enum (IDLE, RUN, DONE);
  - localparam NIBBLE_W=4;
  - a function returning NIBBLES for a given WIDTH.
- One sub-module: the existing `four_bit_adder`, instantiated once as the datapath slice. The FSM, counter and registers are inline.

## Test plan
All scenarios use WIDTH=16.
1. Reset, then a=0x0000, b=0x0000, cin=0 → result 0x0000, cout 0; out_valid exactly 4 cycles after acceptance.
2. a=0x5A5A, b=0xA5A5, cin=0 → 0xFFFF, cout 0. Same operands with cin=1 → 0x0000, cout 1 (carry ripples through all nibbles).
3. a=0xFFFF, b=0xFFFF, cin=1 → result 0xFFFF, cout 1.
4. Hold out_ready=0 for 5 cycles in DONE → result and cout stable, in_ready 0, busy 1, in_valid pulses ignored. Release → next accept no earlier than 1 cycle later.
5. Assert rst during the 2nd RUN cycle → out_valid never rises, result 0, in_ready 1. A following op 0x0001+0x0001 → 0x0002.
6. SUBTRACT_EN build:
   - 0x1234 − 0x0235 → 0x0FFF, cout 1;
   - 0x0001 − 0x0002 → 0xFFFF, cout 0;
   - sub=0 with 0x0001+0x0002 → 0x0003.
